// File: rtl/fifo_sync_param.sv
// Parametrised single-clock FIFO with occupancy count, programmable
// watermarks, sticky error flags and optional first-word-fall-through.
module fifo_sync_param #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 8,
    parameter int AF_LEVEL   = 6,
    parameter int AE_LEVEL   = 2,
    parameter bit FWFT       = 1'b0,
    localparam int CW        = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [CW-1:0]         count,
    output logic                  overflow,
    output logic                  underflow,
    input  logic                  clr_err
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);
    localparam logic [CW-1:0] FULL_C = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C = CW'(AF_LEVEL);
    localparam logic [CW-1:0] AE_C = CW'(AE_LEVEL);
    localparam logic [CW-1:0] ONE = CW'(1);

    if (DEPTH < 2 || AF_LEVEL < 1 || AF_LEVEL > DEPTH ||
        AE_LEVEL < 0 || AE_LEVEL > DEPTH - 1) begin : g_bad_params
        $error("fifo_sync_param: illegal DEPTH/AF_LEVEL/AE_LEVEL");
    end

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [PW-1:0]         wr_nxt;
    logic [PW-1:0]         rd_nxt;
    logic [CW-1:0]         count_nxt;
    logic                  rd_acc;
    logic                  wr_acc;

    assign rd_acc = rd_en && !empty;
    // A full FIFO still takes a write when the same edge pops a word.
    assign wr_acc = wr_en && (!full || rd_acc);
    assign wr_nxt = (wr_ptr == LAST) ? '0 : wr_ptr + PW'(1);
    assign rd_nxt = (rd_ptr == LAST) ? '0 : rd_ptr + PW'(1);

    always_comb begin
        count_nxt = count;
        unique case ({wr_acc, rd_acc})
            2'b10:   count_nxt = count + ONE;
            2'b01:   count_nxt = count - ONE;
            default: count_nxt = count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wr_ptr] <= data_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            full         <= 1'b0;
            empty        <= 1'b1;
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
        end else begin
            if (wr_acc) wr_ptr <= wr_nxt;
            if (rd_acc) rd_ptr <= rd_nxt;
            count        <= count_nxt;
            full         <= (count_nxt == FULL_C);
            empty        <= (count_nxt == '0);
            almost_full  <= (count_nxt >= AF_C);
            almost_empty <= (count_nxt <= AE_C);
        end
    end

    // In FWFT mode the word behind the head may be the one being written now.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_out <= '0;
        end else if (!FWFT) begin
            if (rd_acc) data_out <= mem[rd_ptr];
        end else if (wr_acc && (empty || (rd_acc && count == ONE))) begin
            data_out <= data_in;
        end else if (rd_acc && count != ONE) begin
            data_out <= mem[rd_nxt];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_en && full && !rd_en) overflow <= 1'b1;
            else if (clr_err)            overflow <= 1'b0;
            if (rd_en && empty)          underflow <= 1'b1;
            else if (clr_err)            underflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fifo_sync_param.sv
// Bench for fifo_sync_param: registered and FWFT 8-deep instances plus
// a 5-deep instance, all on shared stimulus, checked against queue models.
module tb_fifo_sync_param;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       wr_en = 1'b0;
    logic       rd_en = 1'b0;
    logic       clr_err = 1'b0;
    logic [7:0] data_in = 8'h00;

    always #5 clk = ~clk;

    logic [7:0] d0, d1, d5;
    logic [3:0] c0, c1;
    logic [2:0] c5;
    logic f0, e0, af0, ae0, o0, u0;
    logic f1, e1, af1, ae1, o1, u1;
    logic f5, e5, af5, ae5, o5, u5;

    fifo_sync_param #(.DATA_WIDTH(8), .DEPTH(8), .AF_LEVEL(6),
                      .AE_LEVEL(2), .FWFT(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .data_in(data_in),
        .rd_en(rd_en), .data_out(d0), .full(f0), .empty(e0),
        .almost_full(af0), .almost_empty(ae0), .count(c0),
        .overflow(o0), .underflow(u0), .clr_err(clr_err));

    fifo_sync_param #(.DATA_WIDTH(8), .DEPTH(8), .AF_LEVEL(6),
                      .AE_LEVEL(2), .FWFT(1'b1)) dut1 (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .data_in(data_in),
        .rd_en(rd_en), .data_out(d1), .full(f1), .empty(e1),
        .almost_full(af1), .almost_empty(ae1), .count(c1),
        .overflow(o1), .underflow(u1), .clr_err(clr_err));

    fifo_sync_param #(.DATA_WIDTH(8), .DEPTH(5), .AF_LEVEL(4),
                      .AE_LEVEL(1), .FWFT(1'b0)) dut5 (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .data_in(data_in),
        .rd_en(rd_en), .data_out(d5), .full(f5), .empty(e5),
        .almost_full(af5), .almost_empty(ae5), .count(c5),
        .overflow(o5), .underflow(u5), .clr_err(clr_err));

    int checks = 0;
    int errors = 0;

    logic [7:0] q8[$];
    logic [7:0] q5[$];
    logic [7:0] e_d0, e_d1, e_d5;
    logic       m_o8, m_u8, m_o5, m_u5;

    typedef struct {
        logic       w;
        logic [7:0] d;
        logic       r;
        logic       c;
        int         cnt;
        logic [5:0] flg;
    } vec_t;

    vec_t tv[18];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        q8.delete();
        q5.delete();
        e_d0 = 8'h00; e_d1 = 8'h00; e_d5 = 8'h00;
        m_o8 = 1'b0; m_u8 = 1'b0; m_o5 = 1'b0; m_u5 = 1'b0;
    endtask

    task automatic chk_all();
        chk("d0", d0, e_d0);
        chk("d1", d1, e_d1);
        chk("d5", d5, e_d5);
        chk("cnt0", c0, q8.size());
        chk("cnt1", c1, q8.size());
        chk("cnt5", c5, q5.size());
        chk("flg0", {f0, af0, e0, ae0, o0, u0},
            {q8.size() == 8, q8.size() >= 6, q8.size() == 0,
             q8.size() <= 2, m_o8, m_u8});
        chk("flg1", {f1, af1, e1, ae1, o1, u1},
            {q8.size() == 8, q8.size() >= 6, q8.size() == 0,
             q8.size() <= 2, m_o8, m_u8});
        chk("flg5", {f5, af5, e5, ae5, o5, u5},
            {q5.size() == 5, q5.size() >= 4, q5.size() == 0,
             q5.size() <= 1, m_o5, m_u5});
    endtask

    task automatic step(input logic w, input logic [7:0] d,
                        input logic r, input logic c);
        logic ra8, wa8, ra5, wa5, so8, su8, so5, su5;
        wr_en = w; data_in = d; rd_en = r; clr_err = c;
        // FWFT head must already be on the port when it is popped
        if (r && q8.size() != 0) chk("fwft_head", d1, q8[0]);
        ra8 = r && q8.size() != 0;
        wa8 = w && (q8.size() < 8 || ra8);
        ra5 = r && q5.size() != 0;
        wa5 = w && (q5.size() < 5 || ra5);
        so8 = w && q8.size() == 8 && !r;
        su8 = r && q8.size() == 0;
        so5 = w && q5.size() == 5 && !r;
        su5 = r && q5.size() == 0;
        @(posedge clk);
        #1;
        if (ra8) e_d0 = q8.pop_front();
        if (wa8) q8.push_back(d);
        if (q8.size() != 0) e_d1 = q8[0];
        if (ra5) e_d5 = q5.pop_front();
        if (wa5) q5.push_back(d);
        m_o8 = so8 | (m_o8 & ~c);
        m_u8 = su8 | (m_u8 & ~c);
        m_o5 = so5 | (m_o5 & ~c);
        m_u5 = su5 | (m_u5 & ~c);
        wr_en = 1'b0; rd_en = 1'b0; clr_err = 1'b0;
        chk_all();
    endtask

    function automatic vec_t mk(input logic w, input logic [7:0] d,
                                input logic r, input int cnt,
                                input logic [5:0] flg);
        vec_t v;
        v.w = w; v.d = d; v.r = r; v.c = 1'b0;
        v.cnt = cnt; v.flg = flg;
        return v;
    endfunction

    initial begin
        // flags: {full, almost_full, empty, almost_empty, overflow, underflow}
        tv[0]  = mk(1, 8'h10, 0, 1, 6'b000100);
        tv[1]  = mk(1, 8'h11, 0, 2, 6'b000100);
        tv[2]  = mk(1, 8'h12, 0, 3, 6'b000000);
        tv[3]  = mk(1, 8'h13, 0, 4, 6'b000000);
        tv[4]  = mk(1, 8'h14, 0, 5, 6'b000000);
        tv[5]  = mk(1, 8'h15, 0, 6, 6'b010000);
        tv[6]  = mk(1, 8'h16, 0, 7, 6'b010000);
        tv[7]  = mk(1, 8'h17, 0, 8, 6'b110000);
        tv[8]  = mk(1, 8'h99, 0, 8, 6'b110010);
        tv[9]  = mk(0, 8'h00, 1, 7, 6'b010010);
        tv[10] = mk(0, 8'h00, 1, 6, 6'b010010);
        tv[11] = mk(0, 8'h00, 1, 5, 6'b000010);
        tv[12] = mk(0, 8'h00, 1, 4, 6'b000010);
        tv[13] = mk(0, 8'h00, 1, 3, 6'b000010);
        tv[14] = mk(0, 8'h00, 1, 2, 6'b000110);
        tv[15] = mk(0, 8'h00, 1, 1, 6'b000110);
        tv[16] = mk(0, 8'h00, 1, 0, 6'b001110);
        tv[17] = mk(0, 8'h00, 1, 0, 6'b001111);

        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cnt", c0, 0);
        chk("rst_flg0", {f0, af0, e0, ae0, o0, u0}, 6'b001100);
        chk_all();
        @(negedge clk);
        rst_n = 1'b1;

        step(1, 8'hAA, 0, 0);
        step(1, 8'hBB, 0, 0);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_cnt", c0, 0);
        chk("arst_empty", e1, 1);
        chk("arst_d1", d1, 8'h00);
        model_reset();
        chk_all();
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 18; i++) begin
            step(tv[i].w, tv[i].d, tv[i].r, tv[i].c);
            chk("tv_cnt0", c0, tv[i].cnt);
            chk("tv_cnt1", c1, tv[i].cnt);
            chk("tv_flg0", {f0, af0, e0, ae0, o0, u0}, tv[i].flg);
            chk("tv_flg1", {f1, af1, e1, ae1, o1, u1}, tv[i].flg);
        end
        chk("drain_hold0", d0, 8'h17);
        chk("drain_hold1", d1, 8'h17);

        for (int i = 0; i < 8; i++) step(1, 8'h20 + 8'(i), 0, 0);
        step(1, 8'hA5, 1, 0);
        chk("sim_full_cnt", c0, 8);
        chk("sim_full_pop", d0, 8'h20);
        for (int i = 0; i < 8; i++) step(0, 8'h00, 1, 0);
        chk("sim_a5_last", d0, 8'hA5);
        step(1, 8'h3C, 1, 0);
        chk("sim_empty_cnt", c0, 1);
        chk("sim_empty_unf", u0, 1);
        chk("sim_empty_fwft", d1, 8'h3C);
        step(0, 8'h00, 1, 0);
        chk("sim_3c_read", d0, 8'h3C);

        chk("err_set", {o0, u0}, 2'b11);
        step(0, 8'h00, 0, 1);
        chk("err_clr", {o0, u0, o1, u1}, 4'b0000);
        for (int i = 0; i < 8; i++) step(1, 8'h30 + 8'(i), 0, 0);
        step(1, 8'hFF, 0, 1);
        chk("err_set_wins", o0, 1);
        for (int i = 0; i < 8; i++) step(0, 8'h00, 1, 0);
        step(0, 8'h00, 0, 1);

        for (int i = 0; i < 20; i++) begin
            step(1, 8'($urandom), 0, 0);
            step(0, 8'h00, 1, 0);
        end
        for (int i = 0; i < 3; i++) step(1, 8'($urandom), 0, 0);
        for (int i = 0; i < 20; i++) step(1, 8'($urandom), 1, 0);
        for (int i = 0; i < 4; i++) step(0, 8'h00, 1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
